// File: rtl/xoodoo_perm_ti_iter_if.sv
// Handshake bundle for the masked Xoodoo core: input shares, fresh randomness stream,
// status flags and output shares.
interface xoodoo_perm_ti_iter_if;
    localparam int unsigned STATE_W = 384;

    logic               start;
    logic [STATE_W-1:0] din_0;
    logic [STATE_W-1:0] din_1;
    logic [STATE_W-1:0] rdi;
    logic               rdi_valid;
    logic               rdi_ready;
    logic               busy;
    logic               done;
    logic [STATE_W-1:0] dout_0;
    logic [STATE_W-1:0] dout_1;

    modport master (
        output start, din_0, din_1, rdi, rdi_valid,
        input  rdi_ready, busy, done, dout_0, dout_1
    );

    modport slave (
        input  start, din_0, din_1, rdi, rdi_valid,
        output rdi_ready, busy, done, dout_0, dout_1
    );
endinterface

// File: rtl/xoodoo_perm_ti_iter.sv
// Iterative 2-share / 3-share threshold-implementation Xoodoo permutation.
// One round datapath, three cycles per round (two randomness fetches, one chi step).
module xoodoo_perm_ti_iter #(
    parameter int unsigned NROUNDS = 12,
    parameter int unsigned RC_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    xoodoo_perm_ti_iter_if.slave bus
);
    localparam int unsigned LANE_W  = 32;
    localparam int unsigned PLANE_W = 4 * LANE_W;
    localparam int unsigned STATE_W = 3 * PLANE_W;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] RC_FIRST = CNT_W'(12 - NROUNDS);
    localparam logic [CNT_W-1:0] RND_LAST = CNT_W'(NROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_R0,
        S_R1,
        S_CHI,
        S_DONE
    } state_t;

    function automatic logic [PLANE_W-1:0] f_lrot(input logic [PLANE_W-1:0] p,
                                                  input int unsigned n);
        logic [PLANE_W-1:0] q;
        q = '0;
        for (int unsigned x = 0; x < 4; x++) begin
            q[LANE_W*x +: LANE_W] = (p[LANE_W*x +: LANE_W] << n)
                                  | (p[LANE_W*x +: LANE_W] >> (LANE_W - n));
        end
        return q;
    endfunction

    // Lane shift along x: new[x] = old[x-k], wrapping mod 4.
    function automatic logic [PLANE_W-1:0] f_xsh(input logic [PLANE_W-1:0] p,
                                                 input int unsigned k);
        return (p << (LANE_W * k)) | (p >> (PLANE_W - LANE_W * k));
    endfunction

    function automatic logic [PLANE_W-1:0] f_pl(input logic [STATE_W-1:0] s,
                                                input int unsigned y);
        return s[PLANE_W*y +: PLANE_W];
    endfunction

    function automatic logic [STATE_W-1:0] f_theta_rhow(input logic [STATE_W-1:0] s);
        logic [PLANE_W-1:0] a0, a1, a2, e;
        a0 = f_pl(s, 0);
        a1 = f_pl(s, 1);
        a2 = f_pl(s, 2);
        e  = f_lrot(f_xsh(a0 ^ a1 ^ a2, 1), 5) ^ f_lrot(f_xsh(a0 ^ a1 ^ a2, 1), 14);
        return {f_lrot(a2 ^ e, 11), f_xsh(a1 ^ e, 1), a0 ^ e};
    endfunction

    function automatic logic [STATE_W-1:0] f_rho_east(input logic [STATE_W-1:0] s);
        return {f_lrot(f_xsh(f_pl(s, 2), 2), 8), f_lrot(f_pl(s, 1), 1), f_pl(s, 0)};
    endfunction

    function automatic logic [STATE_W-1:0] f_chi_y0(input logic [STATE_W-1:0] s0, s1, s2, m);
        logic [STATE_W-1:0] y;
        int unsigned a, b;
        y = '0;
        for (int unsigned p = 0; p < 3; p++) begin
            a = (p + 1) % 3;
            b = (p + 2) % 3;
            y[PLANE_W*p +: PLANE_W] = f_pl(s0, p)
                ^ (f_pl(s1, a) & f_pl(s2, b)) ^ (f_pl(s1, b) & f_pl(s2, a))
                ^ (f_pl(s2, a) & f_pl(s2, b)) ^ f_pl(m, p);
        end
        return y;
    endfunction

    function automatic logic [STATE_W-1:0] f_chi_y1(input logic [STATE_W-1:0] s0, s1, s2, r);
        logic [STATE_W-1:0] y;
        int unsigned a, b;
        y = '0;
        for (int unsigned p = 0; p < 3; p++) begin
            a = (p + 1) % 3;
            b = (p + 2) % 3;
            y[PLANE_W*p +: PLANE_W] = f_pl(s1, p)
                ^ (~f_pl(s0, a) & f_pl(s2, b)) ^ (f_pl(s0, b) & f_pl(s2, a))
                ^ (~f_pl(s0, a) & f_pl(s0, b)) ^ f_pl(r, p);
        end
        return y;
    endfunction

    function automatic logic [STATE_W-1:0] f_chi_y2(input logic [STATE_W-1:0] s0, s1, s2, m, r);
        logic [STATE_W-1:0] y;
        int unsigned a, b;
        y = '0;
        for (int unsigned p = 0; p < 3; p++) begin
            a = (p + 1) % 3;
            b = (p + 2) % 3;
            y[PLANE_W*p +: PLANE_W] = f_pl(s2, p)
                ^ (~f_pl(s0, a) & f_pl(s1, b)) ^ (f_pl(s0, b) & f_pl(s1, a))
                ^ (f_pl(s1, a) & f_pl(s1, b)) ^ f_pl(m, p) ^ f_pl(r, p);
        end
        return y;
    endfunction

    function automatic logic [RC_W-1:0] f_rc(input logic [CNT_W-1:0] idx);
        logic [11:0] v;
        case (idx)
            4'd0:    v = 12'h058;
            4'd1:    v = 12'h038;
            4'd2:    v = 12'h3C0;
            4'd3:    v = 12'h0D0;
            4'd4:    v = 12'h120;
            4'd5:    v = 12'h014;
            4'd6:    v = 12'h060;
            4'd7:    v = 12'h02C;
            4'd8:    v = 12'h380;
            4'd9:    v = 12'h0F0;
            4'd10:   v = 12'h1A0;
            4'd11:   v = 12'h012;
            default: v = 12'h000;
        endcase
        return RC_W'(v);
    endfunction

    state_t             r_state;
    logic [STATE_W-1:0] r_st0, r_st1;
    logic [STATE_W-1:0] r_s0, r_s1, r_s2;
    logic [STATE_W-1:0] r_m, r_r;
    logic [CNT_W-1:0]   r_rnd, r_rc_idx;
    logic               r_busy, r_done, r_rdi_ready;

    logic [RC_W-1:0]    w_rc;
    logic [STATE_W-1:0] w_rc_st;
    logic [STATE_W-1:0] w_l0, w_l1;
    logic [STATE_W-1:0] w_y0, w_y1, w_y2;

    // Linear layer runs per share; the round constant only touches share 0's lane 0.
    assign w_rc    = f_rc(r_rc_idx);
    assign w_rc_st = STATE_W'(w_rc);
    assign w_l0    = f_theta_rhow(r_st0);
    assign w_l1    = f_theta_rhow(r_st1);

    assign w_y0 = f_chi_y0(r_s0, r_s1, r_s2, r_m);
    assign w_y1 = f_chi_y1(r_s0, r_s1, r_s2, r_r);
    assign w_y2 = f_chi_y2(r_s0, r_s1, r_s2, r_m, r_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_st0       <= '0;
            r_st1       <= '0;
            r_s0        <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_m         <= '0;
            r_r         <= '0;
            r_rnd       <= '0;
            r_rc_idx    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rdi_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_st0       <= bus.din_0;
                        r_st1       <= bus.din_1;
                        r_rnd       <= '0;
                        r_rc_idx    <= RC_FIRST;
                        r_busy      <= 1'b1;
                        r_rdi_ready <= 1'b1;
                        r_state     <= S_R0;
                    end
                end
                S_R0: begin
                    if (bus.rdi_valid) begin
                        r_m     <= bus.rdi;
                        r_state <= S_R1;
                    end
                end
                // Re-share the two input shares into three using both fresh words.
                S_R1: begin
                    if (bus.rdi_valid) begin
                        r_r         <= bus.rdi;
                        r_s0        <= r_m ^ bus.rdi;
                        r_s1        <= w_l0 ^ r_m ^ w_rc_st;
                        r_s2        <= w_l1 ^ bus.rdi;
                        r_rdi_ready <= 1'b0;
                        r_state     <= S_CHI;
                    end
                end
                // Collapse three chi shares back to two before rho-east.
                S_CHI: begin
                    r_st0    <= f_rho_east(w_y0);
                    r_st1    <= f_rho_east(w_y1 ^ w_y2);
                    r_rnd    <= r_rnd + CNT_W'(1);
                    r_rc_idx <= r_rc_idx + CNT_W'(1);
                    if (r_rnd == RND_LAST) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_rdi_ready <= 1'b1;
                        r_state     <= S_R0;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_rdi_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rdi_ready = r_rdi_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dout_0    = r_st0;
    assign bus.dout_1    = r_st1;
endmodule

// File: tb/tb_xoodoo_perm_ti_iter.sv
// Bench for the masked Xoodoo core: 12-round and 6-round instances against a lane-array
// reference permutation, with random masks and randomness, stalls, ignored starts and resets.
module tb_xoodoo_perm_ti_iter;
    localparam int unsigned W = 384;
    localparam int MAX_CYC = 300;
    localparam int NVEC = 8;

    typedef struct {
        int           nr;
        logic [W-1:0] secret;
        bit           zero_mask;
        int           stall_xfer;
        int           stall_len;
        bit           poke;
        bit           differ_prev;
        int           exp_lat;
        int           exp_xfer;
        logic [W-1:0] exp_out;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tb_start12 = 1'b0;
    logic         tb_start6 = 1'b0;
    logic         tb_valid = 1'b0;
    logic [W-1:0] tb_din_0 = '0;
    logic [W-1:0] tb_din_1 = '0;
    logic [W-1:0] tb_rdi = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    xoodoo_perm_ti_iter_if bus12 ();
    xoodoo_perm_ti_iter_if bus6 ();

    assign bus12.start     = tb_start12;
    assign bus12.din_0     = tb_din_0;
    assign bus12.din_1     = tb_din_1;
    assign bus12.rdi       = tb_rdi;
    assign bus12.rdi_valid = tb_valid;
    assign bus6.start      = tb_start6;
    assign bus6.din_0      = tb_din_0;
    assign bus6.din_1      = tb_din_1;
    assign bus6.rdi        = tb_rdi;
    assign bus6.rdi_valid  = tb_valid;

    xoodoo_perm_ti_iter #(.NROUNDS(12), .RC_W(32)) u_dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    xoodoo_perm_ti_iter #(.NROUNDS(6), .RC_W(32)) u_dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] ref_rc(input int i);
        case (i)
            0: return 32'h058;   1: return 32'h038;   2: return 32'h3C0;
            3: return 32'h0D0;   4: return 32'h120;   5: return 32'h014;
            6: return 32'h060;   7: return 32'h02C;   8: return 32'h380;
            9: return 32'h0F0;  10: return 32'h1A0;  11: return 32'h012;
            default: return 32'h0;
        endcase
    endfunction

    // Plain Xoodoo on an unmasked [plane][lane] array.
    function automatic logic [W-1:0] ref_perm(input logic [W-1:0] s, input int nr);
        logic [31:0] a [3][4];
        logic [31:0] b [3][4];
        logic [31:0] p [4];
        logic [W-1:0] o;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) a[y][x] = s[32*(4*y+x) +: 32];
        for (int i = 12 - nr; i < 12; i++) begin
            for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++)
                    a[y][x] = a[y][x] ^ rl(p[(x+3)%4], 5) ^ rl(p[(x+3)%4], 14);
            b = a;
            for (int x = 0; x < 4; x++) begin
                a[1][x] = b[1][(x+3)%4];
                a[2][x] = rl(b[2][x], 11);
            end
            a[0][0] = a[0][0] ^ ref_rc(i);
            b = a;
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++)
                    a[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
            b = a;
            for (int x = 0; x < 4; x++) begin
                a[1][x] = rl(b[1][x], 1);
                a[2][x] = rl(b[2][(x+2)%4], 8);
            end
        end
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) o[32*(4*y+x) +: 32] = a[y][x];
        return o;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    function automatic vec_t mk(input int nr, input logic [W-1:0] sec, input bit zm,
                                input int sx, input int sl, input bit pk, input bit dp,
                                input int el, input int ex);
        vec_t v;
        v.nr = nr;  v.secret = sec;  v.zero_mask = zm;
        v.stall_xfer = sx;  v.stall_len = sl;  v.poke = pk;  v.differ_prev = dp;
        v.exp_lat = el;  v.exp_xfer = ex;  v.exp_out = ref_perm(sec, nr);
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ne(input string name, input logic [W-1:0] act, input logic [W-1:0] other);
        n_checks++;
        if (act === other) begin
            n_errors++;
            $display("FAIL %s: got %h which must differ from %h", name, act, other);
        end
    endtask

    task automatic set_start(input int nr, input logic v);
        if (nr == 12) tb_start12 = v;
        else          tb_start6  = v;
    endtask

    task automatic sample(input int nr, output logic dn, output logic bz, output logic rdy,
                          output logic [W-1:0] o0, output logic [W-1:0] o1);
        if (nr == 12) begin
            dn = bus12.done; bz = bus12.busy; rdy = bus12.rdi_ready;
            o0 = bus12.dout_0; o1 = bus12.dout_1;
        end else begin
            dn = bus6.done; bz = bus6.busy; rdy = bus6.rdi_ready;
            o0 = bus6.dout_0; o1 = bus6.dout_1;
        end
    endtask

    // One permutation; cycle k counts negedges after the start cycle.
    task automatic run_perm(input int nr, input logic [W-1:0] d0in, input logic [W-1:0] d1in,
                            input bit zero_rdi, input int stall_xfer, input int stall_len,
                            input bit poke, input int abort_xfer,
                            output int lat, output int xfers,
                            output logic [W-1:0] qx, output logic [W-1:0] hx);
        logic dn, bz, rdy;
        logic [W-1:0] o0, o1;
        int stall_left;
        bit seen;
        @(negedge clk);
        tb_din_0 = d0in;
        tb_din_1 = d1in;
        tb_valid = 1'b1;
        tb_rdi   = zero_rdi ? '0 : rand_w();
        set_start(nr, 1'b1);
        @(negedge clk);
        set_start(nr, 1'b0);
        lat = -1; xfers = 0; stall_left = stall_len; seen = 0; qx = '0; hx = '0;
        for (int k = 1; k <= MAX_CYC; k++) begin
            sample(nr, dn, bz, rdy, o0, o1);
            if (dn) begin
                lat = k; seen = 1; qx = o0 ^ o1;
                break;
            end
            if (k == 1) chk_int("busy_in_run", int'(bz), 1);
            if (abort_xfer >= 0 && xfers == abort_xfer && rdy) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            set_start(nr, (poke && k == 2) ? 1'b1 : 1'b0);
            if (stall_left > 0 && xfers == stall_xfer && rdy) begin
                tb_valid = 1'b0;
                stall_left--;
            end else begin
                tb_valid = 1'b1;
            end
            tb_rdi = zero_rdi ? '0 : rand_w();
            if (rdy && tb_valid) xfers++;
            @(negedge clk);
        end
        chk_int("done_seen", int'(seen), 1);
        if (poke) set_start(nr, 1'b1);
        @(negedge clk);
        set_start(nr, 1'b0);
        sample(nr, dn, bz, rdy, o0, o1);
        chk_int("done_one_cycle", int'(dn), 0);
        chk_int("busy_after_done", int'(bz), 0);
        repeat (2) @(negedge clk);
        sample(nr, dn, bz, rdy, o0, o1);
        chk_int("no_second_done", int'(dn), 0);
        hx = o0 ^ o1;
    endtask

    vec_t vecs [NVEC];
    logic [W-1:0] sec_a, mask, qx, hx, prev_q0, o0, o1;
    logic dn, bz, rdy;
    int lat, xf;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sec_a   = rand_w();
        prev_q0 = '0;
        vecs[0] = mk(12, '0,       1, -1, 0, 0, 0, 37, 24);
        vecs[1] = mk(12, sec_a,    0, -1, 0, 0, 0, 37, 24);
        vecs[2] = mk(12, sec_a,    0, -1, 0, 0, 1, 37, 24);
        vecs[3] = mk(12, sec_a,    0, -1, 0, 0, 1, 37, 24);
        vecs[4] = mk(12, sec_a,    0,  5, 5, 0, 0, 42, 24);
        vecs[5] = mk(6,  rand_w(), 0, -1, 0, 0, 0, 19, 12);
        vecs[6] = mk(6,  '0,       1, -1, 0, 0, 0, 19, 12);
        vecs[7] = mk(12, rand_w(), 0, -1, 0, 1, 0, 37, 24);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        sample(12, dn, bz, rdy, o0, o1);
        chk_int("reset_busy12", int'(bz), 0);
        chk_int("reset_done12", int'(dn), 0);
        chk_int("reset_ready12", int'(rdy), 0);
        chk("reset_dout12", o0 | o1, '0);
        sample(6, dn, bz, rdy, o0, o1);
        chk_int("reset_busy6", int'(bz), 0);
        chk("reset_dout6", o0 | o1, '0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            mask = vecs[i].zero_mask ? '0 : rand_w();
            run_perm(vecs[i].nr, mask, vecs[i].secret ^ mask, vecs[i].zero_mask,
                     vecs[i].stall_xfer, vecs[i].stall_len, vecs[i].poke, -1,
                     lat, xf, qx, hx);
            chk_int($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk_int($sformatf("v%0d_transfers", i), xf, vecs[i].exp_xfer);
            chk($sformatf("v%0d_result", i), qx, vecs[i].exp_out);
            chk($sformatf("v%0d_held", i), hx, vecs[i].exp_out);
            sample(vecs[i].nr, dn, bz, rdy, o0, o1);
            if (vecs[i].differ_prev) chk_ne($sformatf("v%0d_share0_fresh", i), o0, prev_q0);
            prev_q0 = o0;
        end

        // Reset in round 5 aborts the run; the next start must work normally.
        mask = rand_w();
        run_perm(12, mask, sec_a ^ mask, 0, -1, 0, 0, 8, lat, xf, qx, hx);
        sample(12, dn, bz, rdy, o0, o1);
        chk_int("abort_busy", int'(bz), 0);
        chk_int("abort_done", int'(dn), 0);
        chk_int("abort_ready", int'(rdy), 0);
        chk("abort_dout_0", o0, '0);
        chk("abort_dout_1", o1, '0);
        mask = rand_w();
        run_perm(12, mask, sec_a ^ mask, 0, -1, 0, 0, -1, lat, xf, qx, hx);
        chk_int("after_abort_latency", lat, 37);
        chk("after_abort_result", qx, vecs[1].exp_out);

        // Start coinciding with reset is dropped.
        @(negedge clk);
        rst = 1'b1;
        tb_start12 = 1'b1;
        tb_din_0 = rand_w();
        tb_din_1 = rand_w();
        @(negedge clk);
        rst = 1'b0;
        tb_start12 = 1'b0;
        sample(12, dn, bz, rdy, o0, o1);
        chk_int("rst_start_busy", int'(bz), 0);
        chk("rst_start_dout", o0 | o1, '0);
        @(negedge clk);
        sample(12, dn, bz, rdy, o0, o1);
        chk_int("rst_start_idle", int'(bz), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
